// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_pkg : shared types and constants for the PWM button front-end |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_SIM  = 4;
    localparam int DEBOUNCE_CYCLES_FPGA = 25000000;
    localparam int CNT_W                = 28;

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_channel : sync + debounce + hold/auto-repeat for one key   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module button_channel #(
    parameter int DEBOUNCE_CYCLES = pwm_pkg::DEBOUNCE_CYCLES_SIM,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = pwm_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    output logic o_pulse,
    output logic o_level
);
    import pwm_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dly_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rate_last = CNT_W'(REPEAT_RATE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    btn_state_t       r_state;
    logic             w_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    // Any disagreement that does not persist restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt >= c_db_last) begin
            r_stable <= ~r_stable;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_cnt_one;
        end
    end

    // Pulse request is decoded from registered state; the top registers it after masking.
    always_comb begin
        w_pulse = 1'b0;
        if (r_stable) begin
            case (r_state)
                IDLE:    w_pulse = 1'b1;
                HELD:    w_pulse = (REPEAT_EN != 0) && (r_rep_cnt == c_dly_last);
                REPEAT:  w_pulse = (r_rep_cnt == c_rate_last);
                default: w_pulse = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
        end else if (!r_stable) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= HELD;
                    r_rep_cnt <= '0;
                end
                HELD: begin
                    if ((REPEAT_EN != 0) && (r_rep_cnt == c_dly_last)) begin
                        r_state   <= REPEAT;
                        r_rep_cnt <= '0;
                    end else if (r_rep_cnt < c_dly_last) begin
                        r_rep_cnt <= r_rep_cnt + c_cnt_one;
                    end
                end
                REPEAT: begin
                    if (r_rep_cnt >= c_rate_last) begin
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rep_cnt <= '0;
                end
            endcase
        end
    end

    assign o_pulse = w_pulse;
    assign o_level = r_stable;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_conditioner : two-button step-pulse front-end for the PWM  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = pwm_pkg::DEBOUNCE_CYCLES_SIM,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = pwm_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);
    import pwm_pkg::*;

    logic w_inc_pulse;
    logic w_dec_pulse;
    logic r_inc_pulse;
    logic r_dec_pulse;

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN),
        .CNT_W          (CNT_W)
    ) u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_button(increase_duty),
        .o_pulse (w_inc_pulse),
        .o_level (inc_level)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN),
        .CNT_W          (CNT_W)
    ) u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_button(decrease_duty),
        .o_pulse (w_dec_pulse),
        .o_level (dec_level)
    );

    // Coincident requests cancel; the channels themselves keep running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc_pulse <= 1'b0;
            r_dec_pulse <= 1'b0;
        end else begin
            r_inc_pulse <= w_inc_pulse & ~w_dec_pulse;
            r_dec_pulse <= w_dec_pulse & ~w_inc_pulse;
        end
    end

    assign inc_pulse = r_inc_pulse;
    assign dec_pulse = r_dec_pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_button_conditioner : directed + random check against a model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_button_conditioner;
    localparam int DEB  = 4;
    localparam int DLY  = 8;
    localparam int RATE = 4;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic increase_duty = 1'b0;
    logic decrease_duty = 1'b0;
    wire [1:0] inc_p, dec_p, inc_l, dec_l;   // [0] auto-repeat DUT, [1] single-shot DUT

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE),
                         .REPEAT_EN(1), .CNT_W(28)) u_dut_rep (
        .clk(clk), .rst_n(rst_n), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
        .inc_pulse(inc_p[0]), .dec_pulse(dec_p[0]), .inc_level(inc_l[0]), .dec_level(dec_l[0]));

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE),
                         .REPEAT_EN(0), .CNT_W(28)) u_dut_once (
        .clk(clk), .rst_n(rst_n), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
        .inc_pulse(inc_p[1]), .dec_pulse(dec_p[1]), .inc_level(inc_l[1]), .dec_level(dec_l[1]));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: raw samples per edge, accepted level, edge of last acceptance of a press.
    int n = 0;
    int last_rst = 0;
    bit raw_log [2][MAXC];
    bit m_stable [2];
    int m_rise [2];
    bit pm [2][2];
    bit ep [2][2];

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, n, act, exp);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // The synchronizer shows the raw sample taken two edges earlier (zero right after reset).
    function automatic bit presented(input int c, input int e);
        if (e - 2 > last_rst) return raw_log[c][e-2];
        return 1'b0;
    endfunction

    // A new level is accepted once the last DEB presented samples all disagree with the old one.
    function automatic bit accept(input int c);
        for (int j = 0; j < DEB; j++) begin
            if (n - j <= last_rst) return 1'b0;
            if (presented(c, n - j) == m_stable[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit want_pulse(input int d, input int c);
        int a;
        a = n - m_rise[c];
        if (!m_stable[c]) return 1'b0;
        if (a == 0) return 1'b1;
        return (d == 0) && (a >= DLY) && ((a - DLY) % RATE == 0);
    endfunction

    always @(posedge clk) begin
        #1;
        n++;
        if (n >= MAXC) begin
            $display("FAIL model_capacity: got %0d edges, expected below %0d", n, MAXC);
            $fatal(1);
        end
        if (!rst_n) begin
            last_rst = n;
            for (int c = 0; c < 2; c++) begin
                m_stable[c] = 1'b0;
                m_rise[c]   = 0;
                for (int d = 0; d < 2; d++) begin
                    pm[d][c] = 1'b0;
                    ep[d][c] = 1'b0;
                end
            end
        end else begin
            raw_log[0][n] = increase_duty;
            raw_log[1][n] = decrease_duty;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    ep[d][c] = pm[d][c] && !pm[d][1-c];
            for (int c = 0; c < 2; c++) begin
                if (accept(c)) begin
                    m_stable[c] = !m_stable[c];
                    if (m_stable[c]) m_rise[c] = n;
                end
            end
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    pm[d][c] = want_pulse(d, c);
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("inc_pulse[%0d]", d), inc_p[d], ep[d][0]);
            chk($sformatf("dec_pulse[%0d]", d), dec_p[d], ep[d][1]);
            chk($sformatf("inc_level[%0d]", d), inc_l[d], m_stable[0]);
            chk($sformatf("dec_level[%0d]", d), dec_l[d], m_stable[1]);
        end
    end

    // Directed-phase recorders, indexed [dut][channel], edges counted from 1 in each window.
    int pc [2][2];
    int pl [2][2];
    int p1 [2][2];
    int p2 [2][2];
    int p3 [2][2];
    int l1 [2];

    function automatic logic pout(input int d, input int c);
        return (c == 0) ? inc_p[d] : dec_p[d];
    endfunction

    task automatic clear_rec();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                pc[d][c] = 0; pl[d][c] = 0;
                p1[d][c] = -1; p2[d][c] = -1; p3[d][c] = -1;
            end
        l1[0] = -1;
        l1[1] = -1;
    endtask

    task automatic sample(input int k);
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                if (pout(d, c) === 1'b1) begin
                    pc[d][c]++;
                    if (k > 2 + DEB + 1) pl[d][c]++;
                    if (p1[d][c] < 0) p1[d][c] = k;
                    else if (p2[d][c] < 0) p2[d][c] = k;
                    else if (p3[d][c] < 0) p3[d][c] = k;
                end
        if (inc_l[0] === 1'b1 && l1[0] < 0) l1[0] = k;
        if (dec_l[0] === 1'b1 && l1[1] < 0) l1[1] = k;
    endtask

    task automatic set_in(input logic i, input logic d);
        @(negedge clk);
        increase_duty = i;
        decrease_duty = d;
    endtask

    task automatic window(input int ncyc);
        clear_rec();
        for (int k = 1; k <= ncyc; k++) sample(k);
    endtask

    function automatic int hold_len();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 5));
        return int'($urandom_range(6, 40));
    endfunction

    initial begin
        int hi;
        int hd;
        @(posedge clk);
        #2;
        lit("reset_inc_pulse", int'(inc_p[0]), 0);
        lit("reset_dec_pulse", int'(dec_p[0]), 0);
        lit("reset_inc_level", int'(inc_l[0]), 0);
        lit("reset_dec_level", int'(dec_l[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        window(5);

        // Clean press held 40 edges, then release
        set_in(1'b1, 1'b0);
        window(40);
        lit("clean_level_edge", l1[0], 6);
        lit("clean_first_pulse_once", p1[1][0], 7);
        lit("clean_pulse_count_once", pc[1][0], 1);
        lit("repeat_first", p1[0][0], 7);
        lit("repeat_second", p2[0][0], 15);
        lit("repeat_third", p3[0][0], 19);
        lit("repeat_count", pc[0][0], 8);
        lit("clean_dec_quiet", pc[0][1] + pc[1][1], 0);
        set_in(1'b0, 1'b0);
        window(25);
        lit("release_late_pulses", pl[0][0] + pl[1][0], 0);
        lit("release_level", int'(inc_l[0]), 0);

        // Bounce: 1,1,0,0,1,1,0,0 then held high from edge 9
        clear_rec();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            increase_duty = (k > 8) ? 1'b1 : (((k - 1) / 2) % 2 == 0);
            sample(k);
        end
        lit("bounce_first_pulse", p1[1][0], 15);
        lit("bounce_pulse_count_once", pc[1][0], 1);
        lit("bounce_first_pulse_rep", p1[0][0], 15);
        set_in(1'b0, 1'b0);
        window(20);

        // Short glitch on decrease
        clear_rec();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            decrease_duty = (k <= 3);
            sample(k);
        end
        lit("glitch_dec_pulses", pc[0][1] + pc[1][1], 0);
        lit("glitch_dec_level", l1[1], -1);

        // Simultaneous press: every pulse coincides and is masked
        set_in(1'b1, 1'b1);
        window(24);
        lit("simul_pulses", pc[0][0] + pc[0][1] + pc[1][0] + pc[1][1], 0);
        lit("simul_inc_level", l1[0], 6);
        lit("simul_dec_level", l1[1], 6);
        set_in(1'b0, 1'b0);
        window(20);

        // Decrease offset by one cycle
        clear_rec();
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            increase_duty = 1'b1;
            decrease_duty = (k >= 2);
            sample(k);
        end
        lit("offset_inc_first", p1[1][0], 7);
        lit("offset_dec_first", p1[1][1], 8);
        lit("offset_inc_count_rep", pc[0][0], 4);
        lit("offset_dec_count_rep", pc[0][1], 4);
        set_in(1'b0, 1'b0);
        window(20);

        // Reset while auto-repeating, button kept held
        set_in(1'b1, 1'b0);
        window(22);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            lit($sformatf("async_rst_inc_pulse[%0d]", d), int'(inc_p[d]), 0);
            lit($sformatf("async_rst_dec_pulse[%0d]", d), int'(dec_p[d]), 0);
            lit($sformatf("async_rst_inc_level[%0d]", d), int'(inc_l[d]), 0);
            lit($sformatf("async_rst_dec_level[%0d]", d), int'(dec_l[d]), 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        window(12);
        lit("post_rst_level", l1[0], 6);
        lit("post_rst_pulse_rep", p1[0][0], 7);
        lit("post_rst_pulse_once", p1[1][0], 7);
        set_in(1'b0, 1'b0);
        window(20);

        // Random hold lengths, partly correlated, with occasional resets
        hi = 0;
        hd = 0;
        for (int t = 0; t < 2500; t++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            if (hi == 0) begin
                increase_duty = 1'($urandom_range(0, 1));
                hi = hold_len();
                if ($urandom_range(0, 2) == 0) begin
                    decrease_duty = increase_duty;
                    hd = hi;
                end
            end else begin
                hi--;
            end
            if (hd == 0) begin
                decrease_duty = 1'($urandom_range(0, 1));
                hd = hold_len();
            end else begin
                hd--;
            end
        end
        rst_n = 1'b1;
        set_in(1'b0, 1'b0);
        window(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
